// File: rtl/intersection_ctrl_pkg.sv
// Shared definitions for the intersection controller.
//   - 3-bit state encoding (localparams) and the FSM state type
//   - default dwell constants in clock cycles (1 s tick)
//   - dwell counter width and the lamp bundle with its Moore decode
package intersection_ctrl_pkg;

    localparam int CNT_W = 5;

    localparam logic [2:0] ST_MAIN_GREEN  = 3'd0;
    localparam logic [2:0] ST_MAIN_YELLOW = 3'd1;
    localparam logic [2:0] ST_ALL_RED_A   = 3'd2;
    localparam logic [2:0] ST_PED_WALK    = 3'd3;
    localparam logic [2:0] ST_SIDE_GREEN  = 3'd4;
    localparam logic [2:0] ST_SIDE_YELLOW = 3'd5;
    localparam logic [2:0] ST_ALL_RED_B   = 3'd6;

    typedef enum logic [2:0] {
        MAIN_GREEN  = ST_MAIN_GREEN,
        MAIN_YELLOW = ST_MAIN_YELLOW,
        ALL_RED_A   = ST_ALL_RED_A,
        PED_WALK    = ST_PED_WALK,
        SIDE_GREEN  = ST_SIDE_GREEN,
        SIDE_YELLOW = ST_SIDE_YELLOW,
        ALL_RED_B   = ST_ALL_RED_B
    } state_t;

    localparam int DEF_T_MIN_GRN  = 20;
    localparam int DEF_T_SIDE_GRN = 10;
    localparam int DEF_T_YLW      = 3;
    localparam int DEF_T_ALLRED   = 1;
    localparam int DEF_T_WALK     = 8;

    typedef struct packed {
        logic main_grn;
        logic main_ylw;
        logic main_red;
        logic side_grn;
        logic side_ylw;
        logic side_red;
        logic walk;
    } lamps_t;

    // Exactly one lamp per road in every state; the unused encoding
    // falls back to both roads red.
    function automatic lamps_t decode_lamps(state_t s);
        lamps_t l;
        l = '0;
        case (s)
            MAIN_GREEN: begin
                l.main_grn = 1'b1;
                l.side_red = 1'b1;
            end
            MAIN_YELLOW: begin
                l.main_ylw = 1'b1;
                l.side_red = 1'b1;
            end
            SIDE_GREEN: begin
                l.side_grn = 1'b1;
                l.main_red = 1'b1;
            end
            SIDE_YELLOW: begin
                l.side_ylw = 1'b1;
                l.main_red = 1'b1;
            end
            PED_WALK: begin
                l.main_red = 1'b1;
                l.side_red = 1'b1;
                l.walk     = 1'b1;
            end
            default: begin
                l.main_red = 1'b1;
                l.side_red = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_ctrl_if.sv
// Detector/button inputs and lamp outputs of the intersection controller.
//   master : environment side (drives CAR_SIDE/PED, observes lamps)
//   slave  : controller side (observes CAR_SIDE/PED, drives lamps)
interface intersection_ctrl_if;

    logic CAR_SIDE;
    logic PED;
    logic MAIN_GRN;
    logic MAIN_YLW;
    logic MAIN_RED;
    logic SIDE_GRN;
    logic SIDE_YLW;
    logic SIDE_RED;
    logic WALK;

    modport master (
        output CAR_SIDE, PED,
        input  MAIN_GRN, MAIN_YLW, MAIN_RED,
        input  SIDE_GRN, SIDE_YLW, SIDE_RED,
        input  WALK
    );

    modport slave (
        input  CAR_SIDE, PED,
        output MAIN_GRN, MAIN_YLW, MAIN_RED,
        output SIDE_GRN, SIDE_YLW, SIDE_RED,
        output WALK
    );

endinterface

// File: rtl/intersection_ctrl_dwell_timer.sv
// dwell_timer: saturating down-counter with terminal-count flag.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (loads RST_VAL)
//   load_i      : load load_val_i on this edge (state entry)
//   load_val_i  : dwell-1 of the state being entered
//   done_o      : counter reads zero, dwell complete
module dwell_timer
    import intersection_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl: main/side road traffic light sequencer with
// pedestrian walk phase.
// Ports:
//   Clock : 1 Hz system tick
//   Reset : asynchronous active-high, forces MAIN_GREEN immediately
//   bus   : intersection_ctrl_if.slave (CAR_SIDE, PED in; lamps, WALK out)
//
// state       | meaning
// MAIN_GREEN  | main road green, leaves only after min dwell and a request
// MAIN_YELLOW | main road yellow
// ALL_RED_A   | clearance, dispatches walk (priority), side, or main
// PED_WALK    | pedestrian walk, both roads red
// SIDE_GREEN  | side road green
// SIDE_YELLOW | side road yellow
// ALL_RED_B   | clearance, always returns to MAIN_GREEN
module intersection_ctrl
    import intersection_ctrl_pkg::*;
#(
    parameter int T_MIN_GRN  = DEF_T_MIN_GRN,
    parameter int T_SIDE_GRN = DEF_T_SIDE_GRN,
    parameter int T_YLW      = DEF_T_YLW,
    parameter int T_ALLRED   = DEF_T_ALLRED,
    parameter int T_WALK     = DEF_T_WALK
) (
    input  logic                Clock,
    input  logic                Reset,
    intersection_ctrl_if.slave  bus
);

    state_t           state_q, state_d;
    logic             side_req_q, side_req_d;
    logic             ped_req_q, ped_req_d;
    lamps_t           lamps_q, lamps_d;
    logic             dwell_done;
    logic             state_load;
    logic [CNT_W-1:0] load_val;

    function automatic logic [CNT_W-1:0] dwell_of(state_t s);
        logic [CNT_W-1:0] v;
        case (s)
            MAIN_GREEN:               v = CNT_W'(T_MIN_GRN - 1);
            MAIN_YELLOW, SIDE_YELLOW: v = CNT_W'(T_YLW - 1);
            SIDE_GREEN:               v = CNT_W'(T_SIDE_GRN - 1);
            PED_WALK:                 v = CNT_W'(T_WALK - 1);
            default:                  v = CNT_W'(T_ALLRED - 1);
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GREEN: begin
                // Raw inputs are included so a request on the completing
                // edge is not delayed a cycle by the flag register.
                if (dwell_done &&
                    (side_req_q || ped_req_q || bus.CAR_SIDE || bus.PED)) begin
                    state_d = MAIN_YELLOW;
                end
            end
            MAIN_YELLOW: if (dwell_done) state_d = ALL_RED_A;
            ALL_RED_A: begin
                if (dwell_done) begin
                    if (ped_req_q) begin
                        state_d = PED_WALK;
                    end else if (side_req_q) begin
                        state_d = SIDE_GREEN;
                    end else begin
                        state_d = MAIN_GREEN;
                    end
                end
            end
            PED_WALK:    if (dwell_done) state_d = ALL_RED_A;
            SIDE_GREEN:  if (dwell_done) state_d = SIDE_YELLOW;
            SIDE_YELLOW: if (dwell_done) state_d = ALL_RED_B;
            ALL_RED_B:   if (dwell_done) state_d = MAIN_GREEN;
            default:     state_d = MAIN_GREEN;
        endcase
    end

    // Every state change reloads the timer, including the repeated
    // ALL_RED_A entry after a walk phase.
    assign state_load = (state_d != state_q);
    assign load_val   = dwell_of(state_d);

    // Clear has priority over a coincident set on the service-entry edge.
    assign side_req_d = (side_req_q | bus.CAR_SIDE) &
                        ~(state_load && (state_d == SIDE_GREEN));
    assign ped_req_d  = (ped_req_q | bus.PED) &
                        ~(state_load && (state_d == PED_WALK));

    assign lamps_d = decode_lamps(state_d);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= MAIN_GREEN;
            side_req_q <= 1'b0;
            ped_req_q  <= 1'b0;
            lamps_q    <= decode_lamps(MAIN_GREEN);
        end else begin
            state_q    <= state_d;
            side_req_q <= side_req_d;
            ped_req_q  <= ped_req_d;
            lamps_q    <= lamps_d;
        end
    end

    dwell_timer #(
        .RST_VAL (CNT_W'(T_MIN_GRN - 1))
    ) u_dwell (
        .clk        (Clock),
        .rst        (Reset),
        .load_i     (state_load),
        .load_val_i (load_val),
        .done_o     (dwell_done)
    );

    assign bus.MAIN_GRN = lamps_q.main_grn;
    assign bus.MAIN_YLW = lamps_q.main_ylw;
    assign bus.MAIN_RED = lamps_q.main_red;
    assign bus.SIDE_GRN = lamps_q.side_grn;
    assign bus.SIDE_YLW = lamps_q.side_ylw;
    assign bus.SIDE_RED = lamps_q.side_red;
    assign bus.WALK     = lamps_q.walk;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl. Cycle 0 is the clock period that
// starts when Reset is released; lamps are observed on the falling edge.
module tb_intersection_ctrl;

    logic Clock = 1'b0;
    logic Reset;

    intersection_ctrl_if ifc ();

    intersection_ctrl dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ifc)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // {MAIN_GRN, MAIN_YLW, MAIN_RED, SIDE_GRN, SIDE_YLW, SIDE_RED, WALK}
    localparam logic [6:0] L_MG = 7'b1000010;
    localparam logic [6:0] L_MY = 7'b0100010;
    localparam logic [6:0] L_AR = 7'b0010010;
    localparam logic [6:0] L_SG = 7'b0011000;
    localparam logic [6:0] L_SY = 7'b0010100;
    localparam logic [6:0] L_WK = 7'b0010011;

    function automatic logic [6:0] lamps_obs();
        return {ifc.MAIN_GRN, ifc.MAIN_YLW, ifc.MAIN_RED,
                ifc.SIDE_GRN, ifc.SIDE_YLW, ifc.SIDE_RED, ifc.WALK};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Hand-derived lamp schedules per scenario.
    //  0: idle             1: CAR pulse @5 (also used for CAR pulse @19)
    //  2: CAR+PED @3       3: CAR held high
    //  4: CAR @5, PED @26 (during side green)
    function automatic logic [6:0] exp_lamps(int scen, int c);
        int p;
        case (scen)
            0: return L_MG;
            1: begin
                if (c < 20) return L_MG;
                if (c < 23) return L_MY;
                if (c == 23) return L_AR;
                if (c < 34) return L_SG;
                if (c < 37) return L_SY;
                if (c == 37) return L_AR;
                return L_MG;
            end
            2: begin
                if (c < 20) return L_MG;
                if (c < 23) return L_MY;
                if (c == 23) return L_AR;
                if (c < 32) return L_WK;
                if (c == 32) return L_AR;
                if (c < 43) return L_SG;
                if (c < 46) return L_SY;
                if (c == 46) return L_AR;
                return L_MG;
            end
            3: begin
                if (c < 20) return L_MG;
                if (c < 23) return L_MY;
                if (c == 23) return L_AR;
                p = (c - 24) % 38;
                if (p < 10) return L_SG;
                if (p < 13) return L_SY;
                if (p == 13) return L_AR;
                if (p < 34) return L_MG;
                if (p < 37) return L_MY;
                return L_AR;
            end
            default: begin
                if (c < 20) return L_MG;
                if (c < 23) return L_MY;
                if (c == 23) return L_AR;
                if (c < 34) return L_SG;
                if (c < 37) return L_SY;
                if (c == 37) return L_AR;
                if (c < 58) return L_MG;
                if (c < 61) return L_MY;
                if (c == 61) return L_AR;
                if (c < 70) return L_WK;
                if (c == 70) return L_AR;
                return L_MG;
            end
        endcase
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        ifc.CAR_SIDE = 1'b0;
        ifc.PED = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Drives cycles 0..n-1 and checks lamps in each; returns at the start
    // of cycle n with inputs low.
    task automatic run_seq(input string tag, input int scen, input int car_at,
                           input int ped_at, input int n);
        for (int c = 0; c < n; c++) begin
            ifc.CAR_SIDE = (scen == 3) || (c == car_at);
            ifc.PED      = (c == ped_at);
            check($sformatf("%s c%0d", tag, c), lamps_obs(), exp_lamps(scen, c));
            @(negedge Clock);
        end
        ifc.CAR_SIDE = 1'b0;
        ifc.PED = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        ifc.CAR_SIDE = 1'b0;
        ifc.PED = 1'b0;
        #1;
        check("reset_lamps", lamps_obs(), L_MG);
        check("reset_side_req", {6'b0, dut.side_req_q}, 7'b0);
        check("reset_ped_req", {6'b0, dut.ped_req_q}, 7'b0);

        do_reset();
        run_seq("idle", 0, -1, -1, 60);

        do_reset();
        run_seq("car5", 1, 5, -1, 71);

        do_reset();
        run_seq("carped3", 2, 3, 3, 56);

        do_reset();
        run_seq("carheld", 3, -1, -1, 100);

        do_reset();
        run_seq("ped_in_side", 4, 5, 26, 81);

        do_reset();
        run_seq("car19", 1, 19, -1, 41);

        // Asynchronous reset in the middle of side green.
        do_reset();
        run_seq("pre_rst", 4, 5, 26, 29);
        check("pre_rst_lamps", lamps_obs(), L_SG);
        check("pre_rst_ped_req", {6'b0, dut.ped_req_q}, 7'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_lamps", lamps_obs(), L_MG);
        check("mid_rst_side_req", {6'b0, dut.side_req_q}, 7'b0);
        check("mid_rst_ped_req", {6'b0, dut.ped_req_q}, 7'b0);
        Reset = 1'b0;
        @(negedge Clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
